// File: rtl/vote_tally_uart_tx.sv
// vote_tally_uart_tx
//   Snapshots the four 8-bit candidate tallies when send_req is seen in idle. It then
//   transmits them as one 8N1 UART frame: HEADER, cand1..cand4 and, when
//   VOTE_TX_CHECKSUM_EN is defined, an XOR checksum byte. Bytes follow each other
//   with no idle gap.
//
// Configuration macro: VOTE_TX_CHECKSUM_EN (adds the sixth, checksum byte)
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   HEADER        first byte of every frame
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   send_req    level request, sampled only in idle
//   cand1_vote  tally for candidate 1 (likewise cand2..cand4)
//   tx          UART serial line, idle high
//   busy        high while a frame is in flight
//   done        one-cycle pulse in the first idle cycle after a frame

module vote_tally_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_req,
    input  logic [7:0] cand1_vote,
    input  logic [7:0] cand2_vote,
    input  logic [7:0] cand3_vote,
    input  logic [7:0] cand4_vote,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef VOTE_TX_CHECKSUM_EN
    localparam int unsigned NBYTES = 6;
`else
    localparam int unsigned NBYTES = 5;
`endif
    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        byte_idx;
    logic [7:0]        snap1;
    logic [7:0]        snap2;
    logic [7:0]        snap3;
    logic [7:0]        snap4;
    logic [7:0]        cur_byte;
    logic              baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    // Byte currently being serialised, selected from the frozen snapshot.
    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            3'd1:    cur_byte = snap1;
            3'd2:    cur_byte = snap2;
            3'd3:    cur_byte = snap3;
            3'd4:    cur_byte = snap4;
`ifdef VOTE_TX_CHECKSUM_EN
            3'd5:    cur_byte = HEADER ^ snap1 ^ snap2 ^ snap3 ^ snap4;
`endif
            default: cur_byte = HEADER;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            snap1    <= '0;
            snap2    <= '0;
            snap3    <= '0;
            snap4    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (send_req) begin
                        snap1    <= cand1_vote;
                        snap2    <= cand2_vote;
                        snap3    <= cand3_vote;
                        snap4    <= cand4_vote;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                        byte_idx <= '0;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= cur_byte[0];
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= StStop;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx+3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            // First idle cycle carries the done pulse.
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            // Next start bit follows the stop bit with no gap.
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 1'b0;
                            state    <= StStart;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
